pq_buffer_ctrl: RTL and testbench
=================================

# pq_buffer_ctrl

Controller that drives the ping-pong `pq_buffer` in a time-stepped (tick-driven) accumulation pipeline. It accepts a stream of (address, value) accumulation requests and performs saturating read-modify-write on the current write bank through buffer port 1. On each `tick` it swaps banks, then drains the retired bank through port 2. The drain emits every entry on a valid/ready output stream and zeroes each entry behind itself. It sits directly upstream of `pq_buffer` and owns every one of its control, address and data inputs.

## Interface
- `DATA_WIDTH`, 8: accumulator/entry width; must equal the paired `pq_buffer` value.
- `ADDR_WIDTH`, 4: buffer address width; DEPTH = 2**ADDR_WIDTH.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `init`  in  1  pulse: clear both banks; also aborts any activity.
- `tick`  in  1  pulse: time-step boundary (bank swap + drain).
- `acc_valid` / `acc_ready`  in/out  1  accumulation handshake.
- `acc_addr`  in  ADDR_WIDTH  entry to accumulate into.
- `acc_data`  in  DATA_WIDTH  unsigned increment.
- `out_valid` / `out_ready`  out/in  1  drain-stream handshake.
- `out_addr`  out  ADDR_WIDTH  drained entry address.
- `out_data`  out  DATA_WIDTH  drained entry value.
- `busy`  out  1  high during clear sweep or drain.
- `tick_err`  out  1  sticky: a tick was dropped; cleared by `rst`/`init`.
- `ctrl`, `clear`, `rd_en1`, `rd_en2`, `wr_en1`, `wr_en2`  out  1 each  to `pq_buffer`.
- `rd_addr1`, `rd_addr2`, `wr_addr1`, `wr_addr2`  out  ADDR_WIDTH  to `pq_buffer`.
- `din1`, `din2`  out  DATA_WIDTH  to `pq_buffer`.
- `dout1`, `dout2`  in  DATA_WIDTH  from `pq_buffer`.

## Operation
- Main FSM: M_IDLE (after reset) -> M_CLR on `init` -> M_RUN after the last clear address. `init` in any state -> M_CLR.
- M_CLR:
  - `clear`=1 with `din1`=`din2`=0.
  - `wr_addr1` counts 0..DEPTH-1, one address per cycle, so both banks are zeroed in DEPTH cycles.
  - Drain forced idle; `acc_ready`=0.
- M_RUN accumulation, a 2-phase RMW on port 1:
  - P1: handshake accepted; drive `rd_en1`=1, `rd_addr1`=`acc_addr`; register addr and data.
  - P2: `wr_en1`=1, `wr_addr1`=registered addr, `din1`=sat(`dout1`+data), where sat clamps at 2**DATA_WIDTH-1 using a DATA_WIDTH+1-bit sum.
  - `acc_ready`=0 during P2, so throughput is one request per 2 cycles. This guarantees no read-after-write hazard.
- Tick handling:
  - Accepted in M_RUN only when the drain is idle.
  - If P2 is in progress, the swap is deferred one cycle (pending flag); `acc_ready`=0 while a swap is pending.
  - Swap: `ctrl` toggles and the drain starts the next cycle.
  - Tick while drain active, or outside M_RUN: dropped; `tick_err` set (outside M_RUN only while in M_CLR).
- Drain FSM (port 2):
  - D_IDLE -> D_RD: `rd_en2`=1, `rd_addr2`=cnt.
  - D_RD -> D_CAP: capture `dout2` into `out_data`; `out_addr`=cnt; `out_valid`=1.
  - D_CAP -> D_OUT: hold the output until `out_ready`. On the handshake cycle drive `wr_en2`=1, `wr_addr2`=cnt, `din2`=0; `out_valid` drops next cycle.
  - Then cnt==DEPTH-1 -> D_IDLE; otherwise cnt+1 -> D_RD.
- `busy` = (M_CLR) | (drain ≠ D_IDLE).

## Timing
- Reset values:
  - `ctrl`=0 and all enables/`clear`=0.
  - All addresses and `din` = 0; `out_valid`=0, `out_addr`/`out_data`=0.
  - `acc_ready`=0, `busy`=0, `tick_err`=0.
  - State M_IDLE/D_IDLE, counters 0.
- `pq_buffer` read latency is 1 cycle; `ctrl` never changes between a read and its data capture.
- `acc_ready` rises the cycle after entering M_RUN.
- Drain: first `out_valid` 2 cycles after the swap; minimum 3 cycles per entry; DEPTH entries per drain.
- `out_valid`/`out_addr`/`out_data` are stable while `out_ready`=0.
- `init` mid-drain: `out_valid`=0 the next cycle; the clear sweep restarts at address 0; `ctrl` keeps its value.

## Structure
- Shared package `pq_pkg`: main/drain state encodings, DEPTH localparam derivation, saturation-add function.
- One sub-module: `pq_drain` (drain FSM, counter, output register, port-2 drive).
- Top level pairs `pq_buffer_ctrl` with `pq_buffer`.

## Test plan
- Reset, then `init`: `clear`=1 for 16 cycles with `wr_addr1` 0..15, `busy`=1 throughout. `acc_ready`=1 on cycle 17.
- Accumulate addr 3: 5, 5, 250, then `tick`: drain emits addr 0..15. Addr 3 = 255 (saturated); all others 0.
- Second `tick` issued while drain is at addr 4: `tick_err`=1, `ctrl` unchanged, drain continues to 15.
- `out_ready`=0 for 10 cycles at addr 7: `out_valid`=1, data stable, no `wr_en2`. Release -> `wr_en2`=1 at addr 7 with `din2`=0.
- `tick` on the P2 cycle of addr 9 += 4: swap occurs one cycle later; drain reports addr 9 = 4.
- `init` mid-drain at addr 5: `out_valid`=0 next cycle, clear sweep from 0. A subsequent `tick` drains all zeros.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and helpers for the pq_buffer controller.
package pq_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_CLR,
        M_RUN
    } main_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_RD,
        D_CAP,
        D_OUT
    } drain_e;

    function automatic int unsigned depth_of(int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Unsigned add clamped to 2**w-1.
    function automatic logic [31:0] sat_add(
        logic [31:0] a,
        logic [31:0] b,
        int unsigned w
    );
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << w) - 33'd1;
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/pq_buffer_ctrl_drain.sv
// Drain engine: walks the retired bank on port 2, streams each entry
// out on valid/ready and zeroes it once accepted.
module pq_drain
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  abort_i,
    input  logic                  start_i,
    input  logic                  out_ready_i,
    input  logic [DATA_WIDTH-1:0] dout2_i,
    output logic                  out_valid_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  rd_en2_o,
    output logic [ADDR_WIDTH-1:0] rd_addr2_o,
    output logic                  wr_en2_o,
    output logic [ADDR_WIDTH-1:0] wr_addr2_o,
    output logic [DATA_WIDTH-1:0] din2_o,
    output logic                  idle_o
);

    localparam int DEPTH = int'(depth_of(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    drain_e                st_q, st_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q   <= D_IDLE;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        wr     = 1'b0;
        unique case (st_q)
            D_IDLE: if (start_i) st_d = D_RD;
            D_RD:   st_d = D_CAP;
            D_CAP: begin
                data_d = dout2_i;
                st_d   = D_OUT;
            end
            D_OUT: begin
                if (out_ready_i) begin
                    wr = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        st_d  = D_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        st_d  = D_RD;
                    end
                end
            end
            default: st_d = D_IDLE;
        endcase
        if (abort_i) begin
            st_d  = D_IDLE;
            cnt_d = '0;
        end
    end

    assign out_valid_o = (st_q == D_OUT);
    assign out_addr_o  = cnt_q;
    assign out_data_o  = data_q;
    assign rd_en2_o    = (st_q == D_RD);
    assign rd_addr2_o  = cnt_q;
    assign wr_en2_o    = wr;
    assign wr_addr2_o  = cnt_q;
    assign din2_o      = '0;
    assign idle_o      = (st_q == D_IDLE);

endmodule

// File: rtl/pq_buffer_ctrl.sv
// Ping-pong accumulation controller: RMW on port 1, tick-driven
// bank swap, drain of the retired bank on port 2.
module pq_buffer_ctrl
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_i,
    input  logic                  tick_i,
    input  logic                  acc_valid_i,
    output logic                  acc_ready_o,
    input  logic [ADDR_WIDTH-1:0] acc_addr_i,
    input  logic [DATA_WIDTH-1:0] acc_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  busy_o,
    output logic                  tick_err_o,
    output logic                  ctrl_o,
    output logic                  clear_o,
    output logic                  rd_en1_o,
    output logic                  rd_en2_o,
    output logic                  wr_en1_o,
    output logic                  wr_en2_o,
    output logic [ADDR_WIDTH-1:0] rd_addr1_o,
    output logic [ADDR_WIDTH-1:0] rd_addr2_o,
    output logic [ADDR_WIDTH-1:0] wr_addr1_o,
    output logic [ADDR_WIDTH-1:0] wr_addr2_o,
    output logic [DATA_WIDTH-1:0] din1_o,
    output logic [DATA_WIDTH-1:0] din2_o,
    input  logic [DATA_WIDTH-1:0] dout1_i,
    input  logic [DATA_WIDTH-1:0] dout2_i
);

    localparam int DEPTH = int'(depth_of(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    main_e                 m_q, m_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ph2_q, ph2_d;
    logic                  pend_q, pend_d;
    logic                  ctrl_q, ctrl_d;
    logic                  err_q, err_d;
    logic                  swap;
    logic                  acc_fire;
    logic                  drain_idle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q    <= M_IDLE;
            clr_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            ph2_q  <= 1'b0;
            pend_q <= 1'b0;
            ctrl_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            m_q    <= m_d;
            clr_q  <= clr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ph2_q  <= ph2_d;
            pend_q <= pend_d;
            ctrl_q <= ctrl_d;
            err_q  <= err_d;
        end
    end

    assign acc_ready_o = (m_q == M_RUN) && !ph2_q && !pend_q;
    assign acc_fire    = acc_valid_i && acc_ready_o;

    always_comb begin
        m_d    = m_q;
        clr_d  = clr_q;
        addr_d = addr_q;
        data_d = data_q;
        ph2_d  = 1'b0;
        pend_d = pend_q;
        err_d  = err_q;
        swap   = 1'b0;
        unique case (m_q)
            M_IDLE: ;
            M_CLR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST) begin
                    clr_d = '0;
                    m_d   = M_RUN;
                end
                if (tick_i) err_d = 1'b1;
            end
            M_RUN: begin
                ph2_d = acc_fire;
                if (acc_fire) begin
                    addr_d = acc_addr_i;
                    data_d = acc_data_i;
                end
                if (pend_q && !ph2_q) begin
                    swap   = 1'b1;
                    pend_d = 1'b0;
                end
                // A swap must never split a read from its write-back.
                if (tick_i) begin
                    if (!drain_idle || pend_q) err_d = 1'b1;
                    else if (ph2_q || acc_fire) pend_d = 1'b1;
                    else swap = 1'b1;
                end
            end
            default: m_d = M_IDLE;
        endcase
        if (init_i) begin
            m_d    = M_CLR;
            clr_d  = '0;
            ph2_d  = 1'b0;
            pend_d = 1'b0;
            err_d  = 1'b0;
            swap   = 1'b0;
        end
        ctrl_d = swap ? !ctrl_q : ctrl_q;
    end

    assign ctrl_o     = ctrl_q;
    assign clear_o    = (m_q == M_CLR);
    assign tick_err_o = err_q;
    assign busy_o     = clear_o || !drain_idle;
    assign rd_en1_o   = acc_fire;
    assign rd_addr1_o = acc_fire ? acc_addr_i : '0;
    assign wr_en1_o   = ph2_q;
    assign wr_addr1_o = clear_o ? clr_q : (ph2_q ? addr_q : '0);
    assign din1_o     = ph2_q
        ? DATA_WIDTH'(sat_add(32'(dout1_i), 32'(data_q), DATA_WIDTH))
        : '0;

    pq_drain #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_drain (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .abort_i    (init_i),
        .start_i    (swap),
        .out_ready_i(out_ready_i),
        .dout2_i    (dout2_i),
        .out_valid_o(out_valid_o),
        .out_addr_o (out_addr_o),
        .out_data_o (out_data_o),
        .rd_en2_o   (rd_en2_o),
        .rd_addr2_o (rd_addr2_o),
        .wr_en2_o   (wr_en2_o),
        .wr_addr2_o (wr_addr2_o),
        .din2_o     (din2_o),
        .idle_o     (drain_idle)
    );

endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// Bench for pq_buffer_ctrl with a behavioural pq_buffer and a drain scoreboard.
module tb_pq_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic       tick = 1'b0;
    logic       acc_valid = 1'b0;
    logic       acc_ready;
    logic [3:0] acc_addr = '0;
    logic [7:0] acc_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       busy, tick_err, ctrl, clear;
    logic       rd_en1, rd_en2, wr_en1, wr_en2;
    logic [3:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2;
    logic [7:0] din1, din2;
    logic [7:0] dout1, dout2;

    always #5 clk = ~clk;

    pq_buffer_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .init_i(init), .tick_i(tick),
        .acc_valid_i(acc_valid), .acc_ready_o(acc_ready),
        .acc_addr_i(acc_addr), .acc_data_i(acc_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_data_o(out_data),
        .busy_o(busy), .tick_err_o(tick_err), .ctrl_o(ctrl),
        .clear_o(clear), .rd_en1_o(rd_en1), .rd_en2_o(rd_en2),
        .wr_en1_o(wr_en1), .wr_en2_o(wr_en2),
        .rd_addr1_o(rd_addr1), .rd_addr2_o(rd_addr2),
        .wr_addr1_o(wr_addr1), .wr_addr2_o(wr_addr2),
        .din1_o(din1), .din2_o(din2),
        .dout1_i(dout1), .dout2_i(dout2)
    );

    // Behavioural ping-pong buffer: port 1 on bank ctrl, port 2 on !ctrl.
    logic [7:0] bank0 [16];
    logic [7:0] bank1 [16];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                bank0[i] <= 8'(i + 100);
                bank1[i] <= 8'(200 - i);
            end
            dout1 <= '0;
            dout2 <= '0;
        end else begin
            if (clear) begin
                bank0[wr_addr1] <= '0;
                bank1[wr_addr1] <= '0;
            end else begin
                if (wr_en1) begin
                    if (ctrl) bank1[wr_addr1] <= din1;
                    else bank0[wr_addr1] <= din1;
                end
                if (wr_en2) begin
                    if (ctrl) bank0[wr_addr2] <= din2;
                    else bank1[wr_addr2] <= din2;
                end
            end
            if (rd_en1) dout1 <= ctrl ? bank1[rd_addr1] : bank0[rd_addr1];
            if (rd_en2) dout2 <= ctrl ? bank0[rd_addr2] : bank1[rd_addr2];
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    exp_t       q[$];
    logic [7:0] wb [16];
    logic [7:0] ob [16];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL drain_extra: got addr %0d data %0d want none",
                         out_addr, out_data);
            end else begin
                e = q.pop_front();
                if (out_addr != e.a || out_data != e.d) begin
                    bad++;
                    $display("FAIL drain_entry: got %0d=%0d want %0d=%0d",
                             out_addr, out_data, e.a, e.d);
                end
                ob[e.a] = '0;
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic fin();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        mid();
        fin();
    endtask

    task automatic push_swap();
        logic [7:0] t;
        for (int i = 0; i < 16; i++) begin
            q.push_back('{a: 4'(i), d: wb[i]});
            t = wb[i];
            wb[i] = ob[i];
            ob[i] = t;
        end
    endtask

    task automatic acc(input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] e, input bit tk);
        acc_valid = 1'b1;
        acc_addr = a;
        acc_data = d;
        mid();
        chk("p1_ready", int'(acc_ready), 1);
        chk("p1_rd", int'({rd_en1, rd_addr1}), int'({1'b1, a}));
        fin();
        acc_valid = 1'b0;
        tick = tk;
        mid();
        chk("p2_wr", int'({wr_en1, wr_addr1}), int'({1'b1, a}));
        chk("p2_din", int'(din1), int'(e));
        chk("p2_ready", int'(acc_ready), 0);
        fin();
        tick = 1'b0;
        wb[a] = e;
    endtask

    task automatic tick_go();
        logic pre;
        pre = ctrl;
        tick = 1'b1;
        mid();
        push_swap();
        fin();
        tick = 1'b0;
        mid();
        chk("swap_ctrl", int'(ctrl), int'(!pre));
        chk("swap_busy", int'(busy), 1);
        chk("drain_rd", int'({rd_en2, rd_addr2}), int'({1'b1, 4'd0}));
        chk("drain_rd_valid", int'(out_valid), 0);
        fin();
        mid();
        chk("drain_cap_valid", int'(out_valid), 0);
        fin();
        mid();
        chk("first_valid", int'(out_valid), 1);
        fin();
    endtask

    task automatic drain_all();
        for (int n = 0; n < 400 && q.size() > 0; n++) cyc();
        chk("drain_left", q.size(), 0);
        mid();
        chk("drain_done_busy", int'(busy), 0);
        fin();
    endtask

    vec_t tbl[8];
    logic pre_ctrl;
    logic [7:0] hold;
    bit   d4, d7, hit;

    initial begin
        tbl[0] = '{4'd3, 8'd5, 8'd5};
        tbl[1] = '{4'd3, 8'd5, 8'd10};
        tbl[2] = '{4'd3, 8'd250, 8'd255};
        tbl[3] = '{4'd0, 8'd255, 8'd255};
        tbl[4] = '{4'd15, 8'd1, 8'd1};
        tbl[5] = '{4'd15, 8'd254, 8'd255};
        tbl[6] = '{4'd7, 8'd0, 8'd0};
        tbl[7] = '{4'd3, 8'd1, 8'd255};
        for (int i = 0; i < 16; i++) begin
            wb[i] = '0;
            ob[i] = '0;
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        mid();
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_en", int'({clear, rd_en1, rd_en2, wr_en1, wr_en2}), 0);
        chk("rst_addr", int'({rd_addr1, rd_addr2, wr_addr1, wr_addr2}), 0);
        chk("rst_din", int'({din1, din2}), 0);
        chk("rst_out", int'({out_valid, out_addr, out_data}), 0);
        chk("rst_flags", int'({acc_ready, busy, tick_err}), 0);
        fin();
        rst = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        mid();
        chk("idle_tick_no_err", int'(tick_err), 0);
        fin();

        init = 1'b1;
        cyc();
        init = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mid();
            chk("clr_on", int'({clear, busy, acc_ready}), int'(3'b110));
            chk("clr_addr", int'(wr_addr1), i);
            chk("clr_din", int'({din1, din2}), 0);
            fin();
        end
        mid();
        chk("ready_after_clr", int'(acc_ready), 1);
        chk("clr_off", int'(clear), 0);
        fin();

        foreach (tbl[i]) acc(tbl[i].a, tbl[i].d, tbl[i].e, 1'b0);

        tick_go();
        d4 = 1'b0;
        d7 = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 600 && q.size() > 0; n++) begin
            mid();
            if (hit) begin
                hit = 1'b0;
                chk("drop_err", int'(tick_err), 1);
                chk("drop_ctrl", int'(ctrl), int'(pre_ctrl));
            end
            if (out_valid && out_addr == 4'd4 && !d4) begin
                d4 = 1'b1;
                hit = 1'b1;
                pre_ctrl = ctrl;
                tick = 1'b1;
            end
            if (out_valid && out_addr == 4'd7 && !d7) begin
                d7 = 1'b1;
                hold = out_data;
                out_ready = 1'b0;
                fin();
                for (int k = 0; k < 10; k++) begin
                    mid();
                    chk("stall_valid", int'({out_valid, out_addr}),
                        int'({1'b1, 4'd7}));
                    chk("stall_data", int'(out_data), int'(hold));
                    chk("stall_no_wr", int'(wr_en2), 0);
                    fin();
                end
                out_ready = 1'b1;
                mid();
                chk("release_wr", int'({wr_en2, wr_addr2}), int'({1'b1, 4'd7}));
                chk("release_din", int'(din2), 0);
            end
            fin();
            tick = 1'b0;
        end
        chk("drain1_left", q.size(), 0);
        chk("saw_addr4_7", int'({d4, d7}), 3);
        mid();
        chk("err_sticky", int'(tick_err), 1);
        chk("drain1_idle", int'(busy), 0);
        fin();

        pre_ctrl = ctrl;
        acc(4'd9, 8'd4, 8'd4, 1'b1);
        mid();
        chk("defer_ctrl", int'(ctrl), int'(pre_ctrl));
        chk("defer_ready", int'(acc_ready), 0);
        push_swap();
        fin();
        mid();
        chk("defer_swap", int'(ctrl), int'(!pre_ctrl));
        chk("defer_rd", int'(rd_en2), 1);
        fin();
        drain_all();

        acc(4'd5, 8'd77, 8'd77, 1'b0);
        tick_go();
        pre_ctrl = ctrl;
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            mid();
            if (out_valid && out_addr == 4'd5) begin
                hit = 1'b1;
                init = 1'b1;
            end
            fin();
        end
        init = 1'b0;
        chk("init_hit", int'(hit), 1);
        q.delete();
        for (int i = 0; i < 16; i++) begin
            wb[i] = '0;
            ob[i] = '0;
        end
        mid();
        chk("init_valid", int'(out_valid), 0);
        chk("init_clr", int'({clear, wr_addr1}), int'({1'b1, 4'd0}));
        chk("init_err", int'(tick_err), 0);
        chk("init_ctrl", int'(ctrl), int'(pre_ctrl));
        fin();
        for (int i = 1; i < 16; i++) begin
            tick = (i == 3);
            mid();
            chk("reclr_addr", int'(wr_addr1), i);
            if (i == 4) chk("clr_tick_err", int'(tick_err), 1);
            fin();
        end
        tick = 1'b0;
        mid();
        chk("reclr_ready", int'(acc_ready), 1);
        fin();
        tick_go();
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
